// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the instruction fetch/realign stage.
package riscv_fetch_pkg;

  typedef logic [15:0] halfword_t;

  localparam logic [31:0] BUBBLE_INS = 32'h0000_0000;

  // A halfword whose two low bits are not both set starts a 16-bit RVC instruction.
  function automatic logic is_rvc(input halfword_t h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Four-entry halfword queue with same-cycle bypass of the pushed word, so a word
// arriving this cycle can be extracted from immediately.
module fetch_hw_queue
  import riscv_fetch_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_flush,
  input  logic [1:0] i_push_n,
  input  halfword_t i_push0,
  input  halfword_t i_push1,
  input  logic [1:0] i_pop_n,
  output halfword_t o_head0,
  output halfword_t o_head1,
  output logic [2:0] o_avail,
  output logic [2:0] o_count_next
);

  logic [3:0][15:0] r_q;
  logic [2:0]       r_cnt;
  logic [31:0]      w_push;
  logic [63:0]      w_view;
  logic [63:0]      w_shift;

  // Slots at or above r_cnt are kept zero, so the pushed word can simply be OR-ed in.
  assign w_push  = (i_push_n == 2'd2) ? {i_push1, i_push0} :
                   (i_push_n == 2'd1) ? {16'h0000, i_push0} : '0;
  assign w_view  = r_q | ({32'h0000_0000, w_push} << {r_cnt, 4'b0000});
  assign w_shift = w_view >> {i_pop_n, 4'b0000};

  assign o_head0      = w_view[15:0];
  assign o_head1      = w_view[31:16];
  assign o_avail      = r_cnt + {1'b0, i_push_n};
  assign o_count_next = o_avail - {1'b0, i_pop_n};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_shift;
      r_cnt <= o_count_next;
    end
  end

endmodule

// File: rtl/fetch_realign.sv
// IF stage: issues aligned word fetches, realigns halfwords into RV32I/RVC
// instructions and registers the IF/ID outputs with stall and redirect handling.
module fetch_realign
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              dbg,
  input  logic              mem_hold,
  input  logic              hz,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branoff,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_vec,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ins,
  output logic              comp_sig,
  output logic [ADDR_W-1:0] IF_ID_pres_addr
);

  localparam logic [ADDR_W-1:0] MASK4 = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] MASK2 = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] INC2  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] INC4  = ADDR_W'(4);

  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_qpc;
  logic              r_skip_lo;
  logic              r_inflight;
  logic [31:0]       r_ins;
  logic              r_comp;
  logic [ADDR_W-1:0] r_pres;

  logic              w_redirect;
  logic              w_stall;
  logic [ADDR_W-1:0] w_target;
  logic              w_arrive;
  logic [1:0]        w_push_n;
  halfword_t         w_push0;
  halfword_t         w_head0;
  halfword_t         w_head1;
  logic [2:0]        w_avail;
  logic [2:0]        w_count_next;
  logic              w_rvc;
  logic              w_ready;
  logic              w_take;
  logic [1:0]        w_pop_n;
  logic              w_req;

  assign w_redirect = trap | branch;
  assign w_target   = trap ? trap_vec : branoff;
  assign w_stall    = hz | dbg | mem_hold;

  // A response landing in a redirect cycle belongs to the abandoned stream.
  assign w_arrive = r_inflight & ~w_redirect;
  assign w_push_n = !w_arrive ? 2'd0 : (r_skip_lo ? 2'd1 : 2'd2);
  assign w_push0  = r_skip_lo ? imem_rdata[31:16] : imem_rdata[15:0];

  assign w_rvc   = is_rvc(w_head0);
  assign w_ready = w_rvc ? (w_avail >= 3'd1) : (w_avail >= 3'd2);
  assign w_take  = w_ready & ~w_stall & ~w_redirect;
  assign w_pop_n = !w_take ? 2'd0 : (w_rvc ? 2'd1 : 2'd2);

  assign w_req     = ~Rst & (w_redirect | (w_count_next <= 3'd2));
  assign imem_req  = w_req;
  assign imem_addr = w_redirect ? (w_target & MASK4) : r_fpc;

  fetch_hw_queue u_queue (
    .i_clk        (clk),
    .i_rst        (Rst),
    .i_flush      (w_redirect),
    .i_push_n     (w_push_n),
    .i_push0      (w_push0),
    .i_push1      (imem_rdata[31:16]),
    .i_pop_n      (w_pop_n),
    .o_head0      (w_head0),
    .o_head1      (w_head1),
    .o_avail      (w_avail),
    .o_count_next (w_count_next)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_fpc      <= RESET_PC & MASK4;
      r_qpc      <= RESET_PC & MASK2;
      r_skip_lo  <= RESET_PC[1];
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_redirect) begin
        r_fpc     <= (w_target & MASK4) + INC4;
        r_qpc     <= w_target & MASK2;
        r_skip_lo <= w_target[1];
      end else begin
        if (w_req)    r_fpc     <= r_fpc + INC4;
        if (w_arrive) r_skip_lo <= 1'b0;
        if (w_take)   r_qpc     <= r_qpc + (w_rvc ? INC2 : INC4);
      end
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_ins  <= BUBBLE_INS;
      r_comp <= 1'b0;
      r_pres <= RESET_PC;
    end else if (w_redirect) begin
      r_ins  <= BUBBLE_INS;
      r_comp <= 1'b0;
    end else if (!w_stall) begin
      if (w_take) begin
        r_ins  <= w_rvc ? {16'h0000, w_head0} : {w_head1, w_head0};
        r_comp <= w_rvc;
        r_pres <= r_qpc;
      end else begin
        r_ins  <= BUBBLE_INS;
        r_comp <= 1'b0;
      end
    end
  end

  assign ins             = r_ins;
  assign comp_sig        = r_comp;
  assign IF_ID_pres_addr = r_pres;

endmodule

// File: tb/tb_fetch_realign.sv
// Directed bench for fetch_realign with a 1-cycle-latency instruction memory model.
module tb_fetch_realign;

  logic        clk;
  logic        Rst;
  logic        dbg;
  logic        mem_hold;
  logic        hz;
  logic        branch;
  logic [31:0] branoff;
  logic        trap;
  logic [31:0] trap_vec;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        comp_sig;
  logic [31:0] IF_ID_pres_addr;

  logic [31:0] mem [0:255];
  int unsigned n_chk;
  int unsigned n_bad;

  fetch_realign #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .Rst             (Rst),
    .dbg             (dbg),
    .mem_hold        (mem_hold),
    .hz              (hz),
    .branch          (branch),
    .branoff         (branoff),
    .trap            (trap),
    .trap_vec        (trap_vec),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ins             (ins),
    .comp_sig        (comp_sig),
    .IF_ID_pres_addr (IF_ID_pres_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    imem_rdata <= imem_req ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_ins,
                         input logic e_comp, input logic [31:0] e_pc);
    chk({tag, ".ins"},  ins, e_ins);
    chk({tag, ".comp"}, {31'd0, comp_sig}, {31'd0, e_comp});
    chk({tag, ".pc"},   IF_ID_pres_addr, e_pc);
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    branoff = tgt;
    branch  = 1'b1;
    tick();
    branch  = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    Rst = 1'b1; dbg = 1'b0; mem_hold = 1'b0; hz = 1'b0;
    branch = 1'b0; branoff = '0; trap = 1'b0; trap_vec = '0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    // test 1: sequential 32-bit ADDIs from reset
    mem[0] = 32'h0010_0093; mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_0193; mem[3] = 32'h0040_0213;
    // test 2 at 0x40: c.addi x1,1 | c.li x2,3, then add x3,x1,x2
    mem[16] = 32'h410D_0085; mem[17] = 32'h0020_81B3;
    // test 3 at 0x60: c.nop then lw x5,8(x0) spanning words, then c.nop
    mem[24] = 32'h2283_0001; mem[25] = 32'h0001_0080;
    // test 6 trap target 0x80: addi x9,x0,9
    mem[32] = 32'h0090_0493;
    // test 4 at 0x102: addi x6,x0,6 spanning words, then c.nop at 0x106
    mem[64] = 32'h0313_0001; mem[65] = 32'h0001_0060;
    // test 5 at 0x140: addi x1,x0,k+1
    for (int unsigned k = 0; k < 8; k++) mem[80+k] = ((k + 1) << 20) | 32'h93;

    tick(); tick();
    chk_out("rst", 32'h0, 1'b0, 32'h0);
    chk("rst.req", {31'd0, imem_req}, 32'd0);

    Rst = 1'b0;
    #1;
    chk("t1.req", {31'd0, imem_req}, 32'd1);
    chk("t1.addr", imem_addr, 32'h0);
    tick();
    chk_out("t1.bub", 32'h0, 1'b0, 32'h0);
    tick(); chk_out("t1.w0", 32'h0010_0093, 1'b0, 32'h0);
    tick(); chk_out("t1.w1", 32'h0020_0113, 1'b0, 32'h4);
    tick(); chk_out("t1.w2", 32'h0030_0193, 1'b0, 32'h8);
    tick(); chk_out("t1.w3", 32'h0040_0213, 1'b0, 32'hC);

    do_branch(32'h40);
    chk_out("t2.bub", 32'h0, 1'b0, 32'hC);
    tick(); chk_out("t2.caddi", 32'h0000_0085, 1'b1, 32'h40);
    tick(); chk_out("t2.cli",   32'h0000_410D, 1'b1, 32'h42);
    tick(); chk_out("t2.add",   32'h0020_81B3, 1'b0, 32'h44);

    do_branch(32'h60);
    tick(); chk_out("t3.cnop", 32'h0000_0001, 1'b1, 32'h60);
    tick(); chk_out("t3.lw",   32'h0080_2283, 1'b0, 32'h62);
    tick(); chk_out("t3.cnop2", 32'h0000_0001, 1'b1, 32'h66);

    branoff = 32'h102;
    branch  = 1'b1;
    #1;
    chk("t4.req", {31'd0, imem_req}, 32'd1);
    chk("t4.addr", imem_addr, 32'h100);
    tick();
    branch = 1'b0;
    chk("t4.bub1", ins, 32'h0);
    tick(); chk("t4.bub2", ins, 32'h0);
    tick(); chk_out("t4.addi", 32'h0060_0313, 1'b0, 32'h102);
    tick(); chk_out("t4.cnop", 32'h0000_0001, 1'b1, 32'h106);

    do_branch(32'h140);
    tick(); chk_out("t5.w0", 32'h0010_0093, 1'b0, 32'h140);
    hz = 1'b1;
    #1;
    chk("t5.req_h1", {31'd0, imem_req}, 32'd1);
    tick(); chk_out("t5.hold1", 32'h0010_0093, 1'b0, 32'h140);
    chk("t5.req_h2", {31'd0, imem_req}, 32'd0);
    tick(); chk_out("t5.hold2", 32'h0010_0093, 1'b0, 32'h140);
    chk("t5.req_h3", {31'd0, imem_req}, 32'd0);
    tick(); chk_out("t5.hold3", 32'h0010_0093, 1'b0, 32'h140);
    hz = 1'b0;
    for (int unsigned k = 1; k < 5; k++) begin
      tick();
      chk_out("t5.rel", ((k + 1) << 20) | 32'h93, 1'b0, 32'h140 + 4 * k);
    end

    trap     = 1'b1;
    trap_vec = 32'h80;
    branch   = 1'b1;
    branoff  = 32'h40;
    #1;
    chk("t6.addr", imem_addr, 32'h80);
    tick();
    trap = 1'b0; branch = 1'b0;
    chk("t6.bub", ins, 32'h0);
    tick(); chk_out("t6.trap", 32'h0090_0493, 1'b0, 32'h80);
    tick(); chk_out("t6.next", 32'h0000_0013, 1'b0, 32'h84);
    Rst = 1'b1;
    #2;
    chk_out("t6.arst", 32'h0, 1'b0, 32'h0);
    chk("t6.arst_req", {31'd0, imem_req}, 32'd0);
    tick();
    Rst = 1'b0;
    tick(); chk("t6.rbub", ins, 32'h0);
    tick(); chk_out("t6.rw0", 32'h0010_0093, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
